cpu_run_ctrl: RTL and testbench

Synthesizable run controller for the microprocessor. It replaces hand-written reset and clock stimulus with parametrised reset sequencing and gated CPU enables. Modes are free-run, divided-rate run and single-step, plus a PC breakpoint and a saturating executed-cycle counter. It sits between the board clock/reset and the CPU core. Its outputs feed the CPU's reset and clock-enable inputs and the board LED.

---
 rtl/cpu_run_pkg.sv | 20 ++
 rtl/rate_divider.sv | 27 ++
 rtl/cpu_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared encodings for the CPU run controller: run modes, FSM states and a
// small helper for deciding whether a mode runs at full rate.
package cpu_run_pkg;

    localparam logic [1:0] MODE_FREE = 2'b00;
    localparam logic [1:0] MODE_DIV  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_RUN      = 2'd1,
        ST_HALT     = 2'd2
    } runState_t;

    // The unused encoding 2'b11 behaves exactly like free-run.
    function automatic logic modeIsFree(input logic [1:0] m);
        return (m == MODE_FREE) || (m == 2'b11);
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Rate divider for divided-run mode: counts 0..runDiv and ticks on the
// terminal value; a counter already past a lowered runDiv restarts without a tick.
module rate_divider #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] runDiv,
    output logic             tick
);

    logic [DIV_W-1:0] divCnt;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            divCnt <= '0;
        end else if (clear || (divCnt >= runDiv)) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    assign tick = !clear && (divCnt == runDiv);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller between board clock/reset and the CPU core: sequences CPU reset,
// then gates CPU enables for free, divided and single-step execution.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int RESET_CYCLES = 5,
    parameter int ADDR_W       = 8,
    parameter int DIV_W        = 24,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  run_div,
    input  logic              step,
    input  logic              run,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    output logic              CpuReset,
    output logic              CpuEn,
    output logic              Halted,
    output logic [CNT_W-1:0]  CycleCount,
    output logic              LED
);

    localparam logic [7:0] HOLD_LAST = 8'(RESET_CYCLES - 1);

    runState_t        state;
    runState_t        nextState;
    logic [7:0]       holdCnt;
    logic             stepPrev;
    logic             runPrev;
    logic             bpMask;
    logic             stepRise;
    logic             runRise;
    logic             holdDone;
    logic             bpHit;
    logic             divClear;
    logic             divTick;
    logic             enDue;
    logic             cpuResetNext;
    logic             cpuEnNext;
    logic             haltedNext;
    logic             bpMaskNext;
    logic [CNT_W-1:0] countNext;

    assign stepRise = step & ~stepPrev;
    assign runRise  = run & ~runPrev;
    assign holdDone = (holdCnt == HOLD_LAST);
    // bpMask lets the first instruction after a resume execute even at bp_addr.
    assign bpHit    = bp_en && (pc == bp_addr) && !bpMask;
    assign divClear = !((state == ST_RUN) && (mode == MODE_DIV));
    assign enDue    = modeIsFree(mode) ? 1'b1 : divTick;

    rate_divider #(
        .DIV_W (DIV_W)
    ) divider (
        .clk    (clk),
        .Reset  (Reset),
        .clear  (divClear),
        .runDiv (run_div),
        .tick   (divTick)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_RST_HOLD;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_RST_HOLD: begin
                if (holdDone) begin
                    nextState = (mode == MODE_STEP) ? ST_HALT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bpHit || (mode == MODE_STEP)) begin
                    nextState = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!stepRise && runRise && (mode != MODE_STEP)) begin
                    nextState = ST_RUN;
                end
            end
            default: nextState = ST_RST_HOLD;
        endcase
    end

    // Next values for the registered outputs; a step edge in HALT outranks run.
    always_comb begin
        cpuResetNext = (nextState == ST_RST_HOLD);
        haltedNext   = (nextState == ST_HALT);
        cpuEnNext    = 1'b0;
        bpMaskNext   = 1'b0;
        case (state)
            ST_RUN: begin
                cpuEnNext = (nextState == ST_RUN) && enDue;
            end
            ST_HALT: begin
                cpuEnNext  = stepRise;
                bpMaskNext = (nextState == ST_RUN);
            end
            default: begin
                cpuEnNext = 1'b0;
            end
        endcase
        countNext = CycleCount;
        if (cpuEnNext && (CycleCount != {CNT_W{1'b1}})) begin
            countNext = CycleCount + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            CpuReset   <= 1'b1;
            CpuEn      <= 1'b0;
            Halted     <= 1'b0;
            CycleCount <= '0;
            holdCnt    <= 8'd0;
            stepPrev   <= 1'b0;
            runPrev    <= 1'b0;
            bpMask     <= 1'b0;
        end else begin
            CpuReset   <= cpuResetNext;
            CpuEn      <= cpuEnNext;
            Halted     <= haltedNext;
            CycleCount <= countNext;
            holdCnt    <= (nextState == ST_RST_HOLD) ? holdCnt + 8'd1 : 8'd0;
            stepPrev   <= step;
            runPrev    <= run;
            bpMask     <= bpMaskNext;
        end
    end

    assign LED = Halted;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized
// stimulus, all compared against a behavioural model of the run controller.
module tb_cpu_run_ctrl;

    localparam int RESET_CYCLES = 5;
    localparam int ADDR_W       = 8;
    localparam int DIV_W        = 24;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;
    localparam int M_HOLD       = 0;
    localparam int M_RUN        = 1;
    localparam int M_HALT       = 2;

    logic              clk     = 1'b0;
    logic              Reset   = 1'b0;
    logic [1:0]        mode    = 2'b00;
    logic [DIV_W-1:0]  run_div = '0;
    logic              step    = 1'b0;
    logic              run     = 1'b0;
    logic              bp_en   = 1'b0;
    logic [ADDR_W-1:0] bp_addr = '0;
    logic [ADDR_W-1:0] pc      = '0;
    logic              CpuReset;
    logic              CpuEn;
    logic              Halted;
    logic [CNT_W-1:0]  CycleCount;
    logic              LED;

    int checks = 0;
    int errors = 0;
    bit pcAuto = 1'b0;

    int mState;
    int mHoldLeft;
    int mDiv;
    int mCount;
    bit mStepPrev;
    bit mRunPrev;
    bit mMask;
    bit mEn;

    cpu_run_ctrl #(
        .RESET_CYCLES (RESET_CYCLES),
        .ADDR_W       (ADDR_W),
        .DIV_W        (DIV_W),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .mode       (mode),
        .run_div    (run_div),
        .step       (step),
        .run        (run),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .CpuReset   (CpuReset),
        .CpuEn      (CpuEn),
        .Halted     (Halted),
        .CycleCount (CycleCount),
        .LED        (LED)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState    = M_HOLD;
        mHoldLeft = RESET_CYCLES;
        mDiv      = 0;
        mCount    = 0;
        mStepPrev = 1'b0;
        mRunPrev  = 1'b0;
        mMask     = 1'b0;
        mEn       = 1'b0;
    endtask

    // One rising edge of the reference behaviour, using the inputs held before the edge.
    task automatic modelEdge();
        bit sRise;
        bit rRise;
        sRise = step && !mStepPrev;
        rRise = run && !mRunPrev;
        mEn   = 1'b0;
        case (mState)
            M_HOLD: begin
                mHoldLeft--;
                mDiv = 0;
                if (mHoldLeft == 0) mState = (mode == 2'b10) ? M_HALT : M_RUN;
            end
            M_RUN: begin
                if ((bp_en && pc == bp_addr && !mMask) || mode == 2'b10) begin
                    mState = M_HALT;
                    mDiv   = 0;
                end else if (mode == 2'b01) begin
                    if (mDiv == int'(run_div)) begin
                        mEn  = 1'b1;
                        mDiv = 0;
                    end else if (mDiv > int'(run_div)) begin
                        mDiv = 0;
                    end else begin
                        mDiv++;
                    end
                end else begin
                    mEn  = 1'b1;
                    mDiv = 0;
                end
                mMask = 1'b0;
            end
            default: begin
                mDiv = 0;
                if (sRise) begin
                    mEn = 1'b1;
                end else if (rRise && mode != 2'b10) begin
                    mState = M_RUN;
                    mMask  = 1'b1;
                end
            end
        endcase
        if (mEn && mCount < CNT_MAX) mCount++;
        mStepPrev = step;
        mRunPrev  = run;
    endtask

    task automatic compareAll();
        checkOutput("CpuReset", CpuReset, mState == M_HOLD);
        checkOutput("CpuEn", CpuEn, mEn);
        checkOutput("Halted", Halted, mState == M_HALT);
        checkOutput("LED", LED, mState == M_HALT);
        checkOutput("CycleCount", CycleCount, mCount);
    endtask

    // Advance n clock edges, updating the model and checking all outputs 1ns after each edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (Reset) modelReset();
            else modelEdge();
            #1;
            compareAll();
            if (pcAuto && CpuEn === 1'b1) pc = pc + 1'b1;
        end
    endtask

    task automatic asyncReset();
        #2;
        Reset = 1'b1;
        #1;
        modelReset();
        compareAll();
        applyStimulus(2);
    endtask

    task automatic releaseAndMeasure();
        int n;
        n = 0;
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1);
            n++;
            if (CpuReset !== 1'b1) break;
        end
        checkOutput("holdLen", n, RESET_CYCLES);
        checkOutput("countAfterReset", CycleCount, 0);
    endtask

    task automatic countEnables(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1);
            if (CpuEn === 1'b1) seen++;
        end
    endtask

    task automatic runUntilHalt(input string tag);
        int k;
        k = 0;
        while (Halted !== 1'b1 && k < 40) begin
            applyStimulus(1);
            k++;
        end
        checkOutput(tag, Halted, 1'b1);
    endtask

    initial begin
        int seen;
        int enSeen;
        modelReset();
        #2;
        Reset = 1'b1;
        #1;
        compareAll();
        applyStimulus(5);

        // Free run straight out of reset.
        mode = 2'b00;
        releaseAndMeasure();
        enSeen = 0;
        for (int i = 0; i < 30 && enSeen < 10; i++) begin
            applyStimulus(1);
            if (CpuEn === 1'b1) enSeen++;
        end
        checkOutput("count10", CycleCount, 10);

        // Divided run, then shrink the divider mid-run.
        mode    = 2'b01;
        run_div = 3;
        applyStimulus(4);
        countEnables(12, seen);
        checkOutput("div4Enables", seen, 3);
        run_div = 0;
        applyStimulus(4);
        countEnables(8, seen);
        checkOutput("div1Enables", seen, 8);

        // Breakpoint while a simple CPU walks pc upward.
        mode    = 2'b00;
        bp_en   = 1'b1;
        bp_addr = 8'h0C;
        pc      = 8'h08;
        pcAuto  = 1'b1;
        runUntilHalt("bpHalt");
        checkOutput("bpPc", pc, 8'h0C);

        pcAuto = 1'b0;
        step   = 1'b1;
        countEnables(3, seen);
        step   = 1'b0;
        countEnables(2, enSeen);
        checkOutput("stepPulses", seen + enSeen, 1);
        checkOutput("stepHalted", Halted, 1'b1);

        // Resume at the breakpoint address: the first instruction must still run.
        run    = 1'b1;
        applyStimulus(1);
        run    = 1'b0;
        pcAuto = 1'b1;
        applyStimulus(1);
        checkOutput("resumeEn", CpuEn, 1'b1);
        applyStimulus(3);
        pc = 8'h0A;
        runUntilHalt("bpHaltAgain");
        checkOutput("bpPcAgain", pc, 8'h0C);
        pcAuto = 1'b0;

        // Reset while running, then while halted.
        bp_en = 1'b0;
        run   = 1'b1;
        applyStimulus(3);
        run   = 1'b0;
        asyncReset();
        releaseAndMeasure();
        mode = 2'b10;
        asyncReset();
        releaseAndMeasure();
        applyStimulus(2);
        checkOutput("stepModeHalt", Halted, 1'b1);
        asyncReset();
        mode = 2'b00;
        releaseAndMeasure();

        // Counter saturation.
        applyStimulus(25);
        checkOutput("saturated", CycleCount, CNT_MAX);

        // Randomized stimulus.
        for (int i = 0; i < 400; i++) begin
            int r;
            r       = $urandom_range(0, 9);
            mode    = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            run_div = DIV_W'($urandom_range(0, 3));
            step    = ($urandom_range(0, 3) == 0);
            run     = ($urandom_range(0, 3) == 0);
            bp_en   = ($urandom_range(0, 1) == 1);
            bp_addr = ADDR_W'($urandom_range(0, 3));
            pc      = ADDR_W'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                asyncReset();
                Reset = 1'b0;
            end
            applyStimulus(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
